// File: rtl/vga_scan_ctrl_if.sv
// Signal bundle between the raster scan controller, the renderer and the VGA pins.
// The master side is the scan controller, the slave side is the renderer / pin consumer.
interface vga_scan_ctrl_if;
  logic [9:0]  xpos;
  logic [9:0]  ypos;
  logic [2:0]  red_in;
  logic [2:0]  green_in;
  logic [1:0]  blue_in;
  logic        test_en;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [1:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    output xpos, ypos, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, frame_cnt,
    input  red_in, green_in, blue_in, test_en
  );

  modport slave (
    input  xpos, ypos, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, frame_cnt,
    output red_in, green_in, blue_in, test_en
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// Raster scan controller: pixel/line counters, delay-matched sync and blanking,
// registered colour to the pins, frame pulse/counter and a colour-bar test mode.
module vga_scan_ctrl #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int RGB_LAT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vga_scan_ctrl_if.master        bus
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = 80;

  localparam logic [9:0] X_VIS    = 10'(H_VIS);
  localparam logic [9:0] X_HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] X_HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_VIS    = 10'(V_VIS);
  localparam logic [9:0] Y_VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] Y_VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [6:0] BAR_LAST = 7'(BAR_W - 1);

  // Per-pixel attributes that must travel alongside the renderer latency.
  typedef struct packed {
    logic       vis;
    logic       hs_n;
    logic       vs_n;
    logic [2:0] bar;
  } scan_t;

  localparam scan_t SCAN_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, bar: 3'd0};

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [6:0]  r_bar_px;
  logic [2:0]  r_bar;
  logic        r_test;
  logic [2:0]  r_vga_r;
  logic [2:0]  r_vga_g;
  logic [1:0]  r_vga_b;
  logic        r_vga_hs;
  logic        r_vga_vs;
  logic [15:0] r_frame_cnt;

  logic        w_x_wrap;
  logic        w_y_wrap;
  logic        w_frame_start;
  scan_t       w_scan;
  scan_t       w_scan_d;
  logic [2:0]  w_r;
  logic [2:0]  w_g;
  logic [1:0]  w_b;

  assign w_x_wrap      = (r_x == X_LAST);
  assign w_y_wrap      = (r_y == Y_LAST);
  assign w_frame_start = (r_x == 10'd0) && (r_y == Y_VIS);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_x_wrap) begin
      r_x <= '0;
      r_y <= w_y_wrap ? 10'd0 : r_y + 10'd1;
    end else begin
      r_x <= r_x + 10'd1;
    end
  end

  // Bar index tracks x/80 with a sub-counter instead of a divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar_px <= '0;
      r_bar    <= '0;
    end else if (w_x_wrap) begin
      r_bar_px <= '0;
      r_bar    <= '0;
    end else if (r_bar_px == BAR_LAST) begin
      r_bar_px <= '0;
      r_bar    <= r_bar + 3'd1;
    end else begin
      r_bar_px <= r_bar_px + 7'd1;
    end
  end

  // Test mode only changes on the frame wrap; the delayed pixels in flight at
  // that moment are in vertical blanking, so r_test need not be pipelined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_test <= 1'b0;
    end else if (w_x_wrap && w_y_wrap) begin
      r_test <= bus.test_en;
    end
  end

  always_comb begin
    w_scan.vis  = (r_x < X_VIS) && (r_y < Y_VIS);
    w_scan.hs_n = !((r_x >= X_HS_BEG) && (r_x <= X_HS_END));
    w_scan.vs_n = !((r_y >= Y_VS_BEG) && (r_y <= Y_VS_END));
    w_scan.bar  = r_bar;
  end

  generate
    if (RGB_LAT == 0) begin : g_direct
      assign w_scan_d = w_scan;
    end else begin : g_pipe
      scan_t r_pipe [RGB_LAT];

      // NOTE: this small shift register is reset (unlike a RAM) because a
      // restarted scan must emit blank, sync-inactive pixels until it refills.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RGB_LAT; i++) r_pipe[i] <= SCAN_IDLE;
        end else begin
          r_pipe[0] <= w_scan;
          for (int i = 1; i < RGB_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign w_scan_d = r_pipe[RGB_LAT-1];
    end
  endgenerate

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_scan_d.vis) begin
      if (r_test) begin
        w_r = {3{w_scan_d.bar[2]}};
        w_g = {3{w_scan_d.bar[1]}};
        w_b = {2{w_scan_d.bar[0]}};
      end else begin
        w_r = bus.red_in;
        w_g = bus.green_in;
        w_b = bus.blue_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vga_r  <= '0;
      r_vga_g  <= '0;
      r_vga_b  <= '0;
      r_vga_hs <= 1'b1;
      r_vga_vs <= 1'b1;
    end else begin
      r_vga_r  <= w_r;
      r_vga_g  <= w_g;
      r_vga_b  <= w_b;
      r_vga_hs <= w_scan_d.hs_n;
      r_vga_vs <= w_scan_d.vs_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.xpos        = r_x;
  assign bus.ypos        = r_y;
  assign bus.vga_r       = r_vga_r;
  assign bus.vga_g       = r_vga_g;
  assign bus.vga_b       = r_vga_b;
  assign bus.vga_hs      = r_vga_hs;
  assign bus.vga_vs      = r_vga_vs;
  assign bus.frame_start = w_frame_start;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: full-width lines with a shortened frame height,
// one instance with RGB_LAT=0 and one with RGB_LAT=2 sharing clock and reset.
module tb_vga_scan_ctrl;

  localparam int H_TOTAL = 800;
  localparam int V_VIS   = 4;
  localparam int V_FP    = 1;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 1;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
  localparam int VS_BEG  = V_VIS + V_FP;
  localparam int VS_END  = V_VIS + V_FP + V_SYNC - 1;

  localparam logic [2:0] RI = 3'd7;
  localparam logic [2:0] GI = 3'd5;
  localparam logic [1:0] BI = 2'd2;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
  } pins_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   hx [4];
  int   hy [4];

  vga_scan_ctrl_if bus0 ();
  vga_scan_ctrl_if bus2 ();

  vga_scan_ctrl #(.V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .RGB_LAT(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  vga_scan_ctrl #(.V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .RGB_LAT(2))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  function automatic pins_t pins0();
    return {bus0.vga_r, bus0.vga_g, bus0.vga_b, bus0.vga_hs, bus0.vga_vs};
  endfunction

  function automatic pins_t pins2();
    return {bus2.vga_r, bus2.vga_g, bus2.vga_b, bus2.vga_hs, bus2.vga_vs};
  endfunction

  function automatic string fmt(pins_t p);
    return $sformatf("r=%0d g=%0d b=%0d hs=%0b vs=%0b", p.r, p.g, p.b, p.hs, p.vs);
  endfunction

  function automatic pins_t exp_pins(int x, int y, bit test);
    pins_t      p;
    logic [2:0] bar;
    p    = '0;
    p.hs = !(x >= 656 && x <= 751);
    p.vs = !(y >= VS_BEG && y <= VS_END);
    if (x < 640 && y < V_VIS) begin
      if (test) begin
        bar = 3'(x / 80);
        p.r = {3{bar[2]}};
        p.g = {3{bar[1]}};
        p.b = {2{bar[0]}};
      end else begin
        p.r = RI;
        p.g = GI;
        p.b = BI;
      end
    end
    return p;
  endfunction

  task automatic set_inputs(logic [2:0] r, logic [2:0] g, logic [1:0] b, logic t);
    bus0.red_in = r;  bus0.green_in = g;  bus0.blue_in = b;  bus0.test_en = t;
    bus2.red_in = r;  bus2.green_in = g;  bus2.blue_in = b;  bus2.test_en = t;
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 3; i > 0; i--) begin
      hx[i] = hx[i-1];
      hy[i] = hy[i-1];
    end
    hx[0] = int'(bus0.xpos);
    hy[0] = int'(bus0.ypos);
  endtask

  task automatic goto(int x, int y);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (int'(bus0.xpos) == x && int'(bus0.ypos) == y) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL goto_timeout target x=%0d y=%0d now x=%0d y=%0d", x, y, bus0.xpos, bus0.ypos);
    end
  endtask

  task automatic test_reset();
    set_inputs(RI, GI, BI, 1'b0);
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus0.xpos !== 10'd0) begin errors++; $display("FAIL rst_xpos got=%0d exp=0", bus0.xpos); end
    checks++; if (bus0.ypos !== 10'd0) begin errors++; $display("FAIL rst_ypos got=%0d exp=0", bus0.ypos); end
    checks++; if (pins0() !== pins_t'({3'd0, 3'd0, 2'd0, 1'b1, 1'b1})) begin
      errors++; $display("FAIL rst_pins0 got %s exp r=0 g=0 b=0 hs=1 vs=1", fmt(pins0())); end
    checks++; if (pins2() !== pins_t'({3'd0, 3'd0, 2'd0, 1'b1, 1'b1})) begin
      errors++; $display("FAIL rst_pins2 got %s exp r=0 g=0 b=0 hs=1 vs=1", fmt(pins2())); end
    checks++; if (bus0.frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got=%0b exp=0", bus0.frame_start); end
    checks++; if (bus0.frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt got=%0d exp=0", bus0.frame_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_counters();
    int bad = 0;
    int bx  = -1;
    checks++; if (bus0.xpos !== 10'd0) begin errors++; $display("FAIL cnt_start got=%0d exp=0", bus0.xpos); end
    for (int i = 1; i <= 800; i++) begin
      tick();
      if (hx[0] != i % 800 || hy[0] != i / 800) begin
        bad++;
        if (bx < 0) bx = i;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL cnt_sweep got %0d bad cycles (first step %0d) exp 0", bad, bx); end
    checks++; if (bus0.xpos !== 10'd0 || bus0.ypos !== 10'd1) begin
      errors++; $display("FAIL cnt_wrap got x=%0d y=%0d exp x=0 y=1", bus0.xpos, bus0.ypos); end
  endtask

  task automatic test_frames();
    int   pulses = 0, bad_pos = 0, bad_cnt = 0, wide = 0;
    int   hs_last = -1, hs_prev = -1, vs_last = -1, vs_prev = -1;
    logic prev_fs, prev_hs, prev_vs;
    prev_fs = bus0.frame_start;
    prev_hs = bus0.vga_hs;
    prev_vs = bus0.vga_vs;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      if (int'(bus0.frame_cnt) != pulses) bad_cnt++;
      if (bus0.frame_start) begin
        pulses++;
        if (!(hx[0] == 0 && hy[0] == V_VIS)) bad_pos++;
        if (prev_fs) wide++;
      end
      if (prev_hs && !bus0.vga_hs) begin hs_prev = hs_last; hs_last = c; end
      if (prev_vs && !bus0.vga_vs) begin vs_prev = vs_last; vs_last = c; end
      prev_fs = bus0.frame_start;
      prev_hs = bus0.vga_hs;
      prev_vs = bus0.vga_vs;
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL frm_pulses got=%0d exp=3", pulses); end
    checks++; if (bad_pos != 0) begin errors++; $display("FAIL frm_position got %0d off-position pulses exp 0", bad_pos); end
    checks++; if (wide != 0) begin errors++; $display("FAIL frm_width got %0d multi-cycle pulses exp 0", wide); end
    checks++; if (bad_cnt != 0) begin errors++; $display("FAIL frm_cnt_track got %0d bad cycles exp 0", bad_cnt); end
    checks++; if (bus0.frame_cnt !== 16'd3) begin errors++; $display("FAIL frm_cnt got=%0d exp=3", bus0.frame_cnt); end
    checks++; if (hs_last - hs_prev != H_TOTAL) begin errors++; $display("FAIL hs_period got=%0d exp=%0d", hs_last - hs_prev, H_TOTAL); end
    checks++; if (vs_last - vs_prev != FRAME) begin errors++; $display("FAIL vs_period got=%0d exp=%0d", vs_last - vs_prev, FRAME); end
  endtask

  task automatic test_raster();
    int bad0 = 0, bad2 = 0;
    goto(0, 0);
    for (int c = 0; c < FRAME; c++) begin
      tick();
      if (pins0() !== exp_pins(hx[1], hy[1], 1'b0)) bad0++;
      if (pins2() !== exp_pins(hx[3], hy[3], 1'b0)) bad2++;
    end
    checks++; if (bad0 != 0) begin errors++; $display("FAIL raster_lat0 got %0d bad cycles exp 0", bad0); end
    checks++; if (bad2 != 0) begin errors++; $display("FAIL raster_lat2 got %0d bad cycles exp 0", bad2); end
    goto(1, 0);
    checks++; if (pins0() !== pins_t'({RI, GI, BI, 1'b1, 1'b1})) begin errors++; $display("FAIL vis_x0 got %s exp r=7 g=5 b=2 hs=1 vs=1", fmt(pins0())); end
    goto(641, 0);
    checks++; if (pins0() !== pins_t'({3'd0, 3'd0, 2'd0, 1'b1, 1'b1})) begin errors++; $display("FAIL blank_x640 got %s exp r=0 g=0 b=0 hs=1 vs=1", fmt(pins0())); end
    goto(656, 0);
    checks++; if (bus0.vga_hs !== 1'b1) begin errors++; $display("FAIL hs_x655 got=%0b exp=1", bus0.vga_hs); end
    goto(657, 0);
    checks++; if (bus0.vga_hs !== 1'b0) begin errors++; $display("FAIL hs_x656 got=%0b exp=0", bus0.vga_hs); end
    goto(752, 0);
    checks++; if (bus0.vga_hs !== 1'b0) begin errors++; $display("FAIL hs_x751 got=%0b exp=0", bus0.vga_hs); end
    goto(753, 0);
    checks++; if (bus0.vga_hs !== 1'b1) begin errors++; $display("FAIL hs_x752 got=%0b exp=1", bus0.vga_hs); end
    goto(1, V_VIS);
    checks++; if (pins0() !== pins_t'({3'd0, 3'd0, 2'd0, 1'b1, 1'b1})) begin errors++; $display("FAIL blank_yvis got %s exp r=0 g=0 b=0 hs=1 vs=1", fmt(pins0())); end
    goto(0, VS_BEG);
    checks++; if (bus0.vga_vs !== 1'b1) begin errors++; $display("FAIL vs_before got=%0b exp=1", bus0.vga_vs); end
    goto(1, VS_BEG);
    checks++; if (bus0.vga_vs !== 1'b0) begin errors++; $display("FAIL vs_first got=%0b exp=0", bus0.vga_vs); end
    goto(0, VS_END + 1);
    checks++; if (bus0.vga_vs !== 1'b0) begin errors++; $display("FAIL vs_last got=%0b exp=0", bus0.vga_vs); end
    goto(1, VS_END + 1);
    checks++; if (bus0.vga_vs !== 1'b1) begin errors++; $display("FAIL vs_after got=%0b exp=1", bus0.vga_vs); end
  endtask

  task automatic test_test_mode();
    int bad = 0;
    bit wrapped = 1'b0;
    goto(0, 2);
    set_inputs(RI, GI, BI, 1'b1);
    for (int c = 0; c < FRAME + 10 && !wrapped; c++) begin
      tick();
      if (pins0() !== exp_pins(hx[1], hy[1], 1'b0)) bad++;
      if (hx[0] == 0 && hy[0] == 0) wrapped = 1'b1;
    end
    checks++; if (!wrapped || bad != 0) begin errors++; $display("FAIL tm_hold got wrapped=%0b bad=%0d exp wrapped=1 bad=0", wrapped, bad); end
    goto(86, 0);
    checks++; if (pins0() !== pins_t'({3'd0, 3'd0, 2'd3, 1'b1, 1'b1})) begin errors++; $display("FAIL tm_x85 got %s exp r=0 g=0 b=3 hs=1 vs=1", fmt(pins0())); end
    goto(88, 0);
    checks++; if (pins2() !== pins_t'({3'd0, 3'd0, 2'd3, 1'b1, 1'b1})) begin errors++; $display("FAIL tm_x85_lat2 got %s exp r=0 g=0 b=3 hs=1 vs=1", fmt(pins2())); end
    goto(241, 0);
    checks++; if (pins0() !== pins_t'({3'd0, 3'd7, 2'd3, 1'b1, 1'b1})) begin errors++; $display("FAIL tm_x240 got %s exp r=0 g=7 b=3 hs=1 vs=1", fmt(pins0())); end
    goto(521, 0);
    checks++; if (pins0() !== pins_t'({3'd7, 3'd7, 2'd0, 1'b1, 1'b1})) begin errors++; $display("FAIL tm_x520 got %s exp r=7 g=7 b=0 hs=1 vs=1", fmt(pins0())); end
    goto(601, 0);
    checks++; if (pins0() !== pins_t'({3'd7, 3'd7, 2'd3, 1'b1, 1'b1})) begin errors++; $display("FAIL tm_x600 got %s exp r=7 g=7 b=3 hs=1 vs=1", fmt(pins0())); end
    goto(701, 0);
    checks++; if (pins0() !== pins_t'({3'd0, 3'd0, 2'd0, 1'b0, 1'b1})) begin errors++; $display("FAIL tm_blank got %s exp r=0 g=0 b=0 hs=0 vs=1", fmt(pins0())); end
    goto(0, 1);
    set_inputs(RI, GI, BI, 1'b0);
    goto(86, 2);
    checks++; if (pins0() !== pins_t'({3'd0, 3'd0, 2'd3, 1'b1, 1'b1})) begin errors++; $display("FAIL tm_off_hold got %s exp r=0 g=0 b=3 hs=1 vs=1", fmt(pins0())); end
    goto(0, 0);
    goto(86, 0);
    checks++; if (pins0() !== pins_t'({RI, GI, BI, 1'b1, 1'b1})) begin errors++; $display("FAIL tm_off got %s exp r=7 g=5 b=2 hs=1 vs=1", fmt(pins0())); end
  endtask

  task automatic test_reset_mid();
    int early = 0;
    bit reached = 1'b0;
    goto(300, 2);
    rst_n = 1'b0;
    #1;
    checks++; if (pins0() !== pins_t'({3'd0, 3'd0, 2'd0, 1'b1, 1'b1})) begin errors++; $display("FAIL mid_pins0 got %s exp r=0 g=0 b=0 hs=1 vs=1", fmt(pins0())); end
    checks++; if (pins2() !== pins_t'({3'd0, 3'd0, 2'd0, 1'b1, 1'b1})) begin errors++; $display("FAIL mid_pins2 got %s exp r=0 g=0 b=0 hs=1 vs=1", fmt(pins2())); end
    checks++; if (bus0.xpos !== 10'd0 || bus0.ypos !== 10'd0) begin errors++; $display("FAIL mid_xy got x=%0d y=%0d exp x=0 y=0", bus0.xpos, bus0.ypos); end
    checks++; if (bus0.frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt got=%0d exp=0", bus0.frame_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus0.xpos !== 10'd1 || bus0.ypos !== 10'd0) begin errors++; $display("FAIL mid_resume got x=%0d y=%0d exp x=1 y=0", bus0.xpos, bus0.ypos); end
    checks++; if (pins0() !== pins_t'({RI, GI, BI, 1'b1, 1'b1})) begin errors++; $display("FAIL mid_first_lat0 got %s exp r=7 g=5 b=2 hs=1 vs=1", fmt(pins0())); end
    checks++; if (pins2() !== pins_t'({3'd0, 3'd0, 2'd0, 1'b1, 1'b1})) begin errors++; $display("FAIL mid_blank1_lat2 got %s exp r=0 g=0 b=0 hs=1 vs=1", fmt(pins2())); end
    tick();
    checks++; if (pins2() !== pins_t'({3'd0, 3'd0, 2'd0, 1'b1, 1'b1})) begin errors++; $display("FAIL mid_blank2_lat2 got %s exp r=0 g=0 b=0 hs=1 vs=1", fmt(pins2())); end
    tick();
    checks++; if (pins2() !== pins_t'({RI, GI, BI, 1'b1, 1'b1})) begin errors++; $display("FAIL mid_fill_lat2 got %s exp r=7 g=5 b=2 hs=1 vs=1", fmt(pins2())); end
    for (int c = 0; c < FRAME && !reached; c++) begin
      if (hx[0] == 0 && hy[0] == V_VIS) reached = 1'b1;
      else begin
        if (bus0.frame_start) early++;
        tick();
      end
    end
    checks++; if (!reached || early != 0) begin errors++; $display("FAIL mid_no_early_fs got reached=%0b early=%0d exp reached=1 early=0", reached, early); end
    checks++; if (bus0.frame_start !== 1'b1) begin errors++; $display("FAIL mid_fs_at_vis got=%0b exp=1", bus0.frame_start); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      hx[i] = 0;
      hy[i] = 0;
    end
    set_inputs(RI, GI, BI, 1'b0);
    test_reset();
    test_counters();
    test_frames();
    test_raster();
    test_test_mode();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
